// File: rtl/mem_rd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_rd_ctrl_pkg
// Shared types and defaults for the multi-channel memory read controller.
//   state_e      : controller FSM states (IDLE, HOLD, RESP)
//   DEF_*        : default parameter values used by the interface and modules
//   idx_w()      : width of a channel index, never narrower than one bit
// -----------------------------------------------------------------------------
package mem_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RD_HOLD = 2;

  // A single-channel build still needs a 1-bit index/pointer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_rd_ctrl_if
// Bundles the requester handshake, memory bus and response signals of
// mem_rd_ctrl.
//   ce         : chip enable, gates acceptance of new requests
//   req        : per-channel level request, held until gnt
//   req_addr   : per-channel read address
//   gnt        : one-hot single-cycle accept pulse
//   mem_rd     : memory read strobe
//   mem_addr   : memory address
//   mem_rdata  : memory read data
//   rsp_valid  : single-cycle response pulse
//   rsp_ch     : channel the response belongs to
//   rsp_data   : captured read data
//   busy       : controller not idle
// Modports:
//   master : requester / memory side (drives ce, req, req_addr, mem_rdata)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface mem_rd_ctrl_if
  import mem_rd_ctrl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int IDX_W = idx_w(NUM_CH);

  logic                           ce;
  logic [NUM_CH-1:0]              req;
  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr;
  logic [NUM_CH-1:0]              gnt;
  logic                           mem_rd;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_rdata;
  logic                           rsp_valid;
  logic [IDX_W-1:0]               rsp_ch;
  logic [DATA_W-1:0]              rsp_data;
  logic                           busy;

  modport master (
    output ce, req, req_addr, mem_rdata,
    input  gnt, mem_rd, mem_addr, rsp_valid, rsp_ch, rsp_data, busy
  );

  modport slave (
    input  ce, req, req_addr, mem_rdata,
    output gnt, mem_rd, mem_addr, rsp_valid, rsp_ch, rsp_data, busy
  );

endinterface

// File: rtl/mem_rd_ctrl_rr_arb.sv
// -----------------------------------------------------------------------------
// mem_rd_ctrl_rr_arb
// Combinational round-robin selector.
//   req : request vector
//   ptr : highest-priority channel for this decision
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : index of the granted channel
//   any : at least one request present
// The search starts at ptr and wraps: the lowest requesting channel at or
// above ptr wins, otherwise the lowest requesting channel overall.
// -----------------------------------------------------------------------------
module mem_rd_ctrl_rr_arb
  import mem_rd_ctrl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan so the last hit is the lowest qualifying index.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
      if (req[i] && (i >= int'(ptr))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
    idx = hi_found ? hi_idx : lo_idx;
    any = lo_found;
    gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = lo_found && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mem_rd_ctrl.sv
// -----------------------------------------------------------------------------
// mem_rd_ctrl
// Arbitrates NUM_CH read requesters onto one memory read port. A request is
// accepted in IDLE (ce=1), mem_rd is then held for RD_HOLD cycles with a
// stable address, the read data is captured and returned with a one-cycle
// rsp_valid pulse. Latency accept->rsp_valid is RD_HOLD+1 cycles, one read
// per RD_HOLD+2 cycles.
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-low reset
//   bus : mem_rd_ctrl_if.slave (ce, req, req_addr, gnt, mem_rd, mem_addr,
//         mem_rdata, rsp_valid, rsp_ch, rsp_data, busy)
// Parameters: NUM_CH (1..16), ADDR_W, DATA_W, RD_HOLD (>=1)
// Configuration: define MEM_RD_CTRL_ASSERT_EN to compile in protocol
// assertions; without it the design contains no assertion code.
// -----------------------------------------------------------------------------
module mem_rd_ctrl
  import mem_rd_ctrl_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_HOLD = DEF_RD_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  mem_rd_ctrl_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_CH);
  localparam int CNT_W = idx_w(RD_HOLD);

  if (RD_HOLD < 1) begin : g_bad_rd_hold
    $error("mem_rd_ctrl: RD_HOLD must be >= 1");
  end
  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("mem_rd_ctrl: NUM_CH must be in 1..16");
  end

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  sel;
  logic [NUM_CH-1:0] gnt_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rsp_valid_q;
  logic [IDX_W-1:0]  rsp_ch_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              busy_q;

  logic [NUM_CH-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [IDX_W-1:0]  ptr_nxt;

  mem_rd_ctrl_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // One-hot address mux driven by the arbiter grant.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) sel_addr = bus.req_addr[i];
    end
  end

  // Next round-robin start: channel after the one being granted.
  assign ptr_nxt = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      sel         <= '0;
      gnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ce && arb_any) begin
            sel        <= arb_idx;
            gnt_q      <= arb_gnt;
            mem_addr_q <= sel_addr;
            mem_rd_q   <= 1'b1;
            cnt        <= CNT_W'(RD_HOLD - 1);
            ptr        <= ptr_nxt;
            busy_q     <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // cnt counts the HOLD cycles still to go after the current one.
          if (cnt == '0) begin
            mem_rd_q    <= 1'b0;
            rsp_data_q  <= bus.mem_rdata;
            rsp_valid_q <= 1'b1;
            rsp_ch_q    <= sel;
            state       <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ch    = rsp_ch_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;

`ifdef MEM_RD_CTRL_ASSERT_EN
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(gnt_q));

  a_rsp_one_cycle : assert property (@(posedge clk) disable iff (!rst)
    rsp_valid_q |=> !rsp_valid_q);

  a_rd_hold_len : assert property (@(posedge clk) disable iff (!rst)
    $rose(mem_rd_q) |-> mem_rd_q [*RD_HOLD] ##1 !mem_rd_q);

  a_addr_stable : assert property (@(posedge clk) disable iff (!rst)
    (mem_rd_q && $past(mem_rd_q)) |-> $stable(mem_addr_q));
`else
`endif

endmodule

// File: doc/mem_rd_ctrl.md
MEM_RD_CTRL -- requirements
Module: mem_rd_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting channels; SHALL be 1..16.
REQ-002 Parameter ADDR_W, default 8, address width.
REQ-003 Parameter DATA_W, default 8, read data width.
REQ-004 Parameter RD_HOLD, default 2, cycles mem_rd is held per read; SHALL be >=1, and 0 SHALL raise an elaboration error.
REQ-005 Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-low reset.
- ce  in  1  chip enable; gates acceptance of new requests.
- req  in  NUM_CH  per-channel read request, level, held until gnt.
- req_addr  in  NUM_CH x ADDR_W  per-channel read address.
- gnt  out  NUM_CH  one-hot, one-cycle accept pulse.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_rdata  in  DATA_W  memory read data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_ch  out  $clog2(NUM_CH) (min 1)  channel of response.
- rsp_data  out  DATA_W  read data.
- busy  out  1  high in any state other than IDLE.

Function
REQ-006 FSM states SHALL be IDLE, HOLD and RESP.
REQ-007 In IDLE, at an edge with ce=1 and any req bit set, the block SHALL select one channel by round-robin, latch its req_addr, and move to HOLD.
REQ-008 For the cycle after that edge, gnt[sel] SHALL be 1 and all other gnt bits 0.
REQ-009 In HOLD, mem_rd SHALL be 1 for exactly RD_HOLD consecutive cycles, and mem_addr SHALL equal the latched address, stable throughout.
REQ-010 At the edge ending the last HOLD cycle, the block SHALL capture mem_rdata into rsp_data and move to RESP.
REQ-011 In RESP, rsp_valid SHALL be 1 for one cycle with rsp_ch=sel; the FSM SHALL return to IDLE on the next edge.
REQ-012 Latency from the accept edge to rsp_valid high SHALL be RD_HOLD+1 cycles; throughput SHALL be one read per RD_HOLD+2 cycles.
REQ-013 Round-robin priority SHALL start at the channel after the last granted one, wrapping from NUM_CH-1 to 0.
REQ-014 With NUM_CH=1, the block SHALL grant channel 0 whenever req[0]=1.
REQ-015 With ce=0 or req=0 in IDLE, the block SHALL stay in IDLE and gnt, mem_rd and rsp_valid SHALL be 0.
REQ-016 A ce deassert during HOLD or RESP SHALL NOT abort the transaction; it SHALL complete normally.
REQ-017 Changes on req or req_addr during HOLD SHALL NOT affect mem_addr.
REQ-018 Outside HOLD, mem_rd SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-019 rst=0 at an edge SHALL force the following on that edge:
- state IDLE, round-robin pointer 0;
- gnt, mem_rd, rsp_valid and busy to 0;
- mem_addr, rsp_ch and rsp_data to 0.
REQ-020 A reset asserted mid-HOLD or mid-RESP SHALL discard the transaction, with no rsp_valid.
REQ-021 The first request SHALL be accepted no earlier than the first edge with rst=1.

Configuration
REQ-022 With MEM_RD_CTRL_ASSERT_EN defined, the block SHALL compile in concurrent assertions covering REQ-009 (mem_rd held RD_HOLD cycles, mem_addr stable), REQ-008 (gnt one-hot) and REQ-011 (one-cycle rsp_valid), each disabled while rst=0.
REQ-023 Without MEM_RD_CTRL_ASSERT_EN, no assertion code SHALL be present, and behaviour SHALL be otherwise identical.

Structure
REQ-024 Package mem_rd_ctrl_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-025 Round-robin selection SHALL be a sub-module mem_rd_ctrl_rr_arb: req vector and pointer in, one-hot grant and index out.

Verification
REQ-026 Reset, then ce=1, req=4'b0001, req_addr[0]=8'h3C -> gnt=0001 next cycle; mem_rd=1 with mem_addr=8'h3C for 2 cycles; rsp_valid=1, rsp_ch=0, rsp_data=mem_rdata 3 cycles after the accept edge.
REQ-027 req=4'b1111 held for 4 transactions -> grants to channels 0,1,2,3 in order, then 0 again (wrap).
REQ-028 ce=0 with req=4'b0010 -> no gnt or mem_rd for 10 cycles; ce=1 -> grant to channel 1.
REQ-029 req_addr[0] changed from 8'h3C to 8'hA5 during HOLD -> mem_addr stays 8'h3C; with MEM_RD_CTRL_ASSERT_EN, no assertion failure.
REQ-030 rst=0 in the 1st HOLD cycle -> next cycle all outputs 0, no rsp_valid; the next request is granted to channel 0.
REQ-031 RD_HOLD=4, NUM_CH=1 -> mem_rd high 4 cycles, rsp_valid 5 cycles after accept.
